// File: rtl/jpeg_fifo_pkg.sv
// rtl/jpeg_fifo_pkg.sv - shared types and constants for the JPEG output FIFO read scheduler
package jpeg_fifo_pkg;

    localparam int NUM_CH     = 3;
    localparam int FIFO_DEPTH = 16;
    localparam int LEN_W      = 5;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } chan_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // MCU order Y -> Cb -> Cr -> Y
    function automatic chan_t next_chan(input chan_t c);
        case (c)
            CH_Y:    return CH_CB;
            CH_CB:   return CH_CR;
            default: return CH_Y;
        endcase
    endfunction

endpackage

// File: rtl/fifo_blk_tracker.sv
// rtl/fifo_blk_tracker.sv - per-channel pending-block flag, word count and protocol error detect
module fifo_blk_tracker
    import jpeg_fifo_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_done,
    input  logic [LEN_W-1:0] blk_words,
    input  logic             clr,
    output logic             pend,
    output logic [LEN_W-1:0] len,
    output logic             blk_ready,
    output logic             err
);

    logic [LEN_W-1:0] words_clamped;

    assign words_clamped = (blk_words > LEN_W'(FIFO_DEPTH)) ? LEN_W'(FIFO_DEPTH) : blk_words;
    assign blk_ready     = !pend;
    // A blk_done in the clearing cycle still sees pend=1 and is flagged.
    assign err           = blk_done && pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            len  <= '0;
        end else if (clr) begin
            pend <= 1'b0;
        end else if (blk_done && !pend) begin
            pend <= 1'b1;
            len  <= words_clamped;
        end
    end

endmodule

// File: rtl/fifo_read_scheduler.sv
// rtl/fifo_read_scheduler.sv - drains Y/Cb/Cr block FIFOs in MCU order into one tagged word stream
module fifo_read_scheduler
    import jpeg_fifo_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            blk_done,
    input  logic [2:0][LEN_W-1:0] blk_words,
    output logic [2:0]            blk_ready,
    input  logic [2:0]            fifo_empty,
    input  logic [2:0]            fifo_rdata_valid,
    input  logic [2:0][31:0]      fifo_rdata,
    output logic [2:0]            fifo_read_req,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    output logic [1:0]            out_chan,
    output logic                  out_last,
    output logic                  mcu_done,
    output logic                  proto_err
);

    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    logic [1:0]            state;
    chan_t                 cur;
    logic [1:0]            cur_idx;
    logic [LEN_W-1:0]      cnt;
    logic [LEN_W-1:0]      outstanding;
    logic [2:0]            pend;
    logic [2:0][LEN_W-1:0] len;
    logic [2:0]            err;
    logic [2:0]            clr;

    logic cur_pend;
    logic cur_valid;
    logic rd_fire;
    logic word_ok;
    logic last_ret;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_trk
        fifo_blk_tracker #(.LEN_W(LEN_W)) u_trk (
            .clk       (clk),
            .rst       (rst),
            .blk_done  (blk_done[c]),
            .blk_words (blk_words[c]),
            .clr       (clr[c]),
            .pend      (pend[c]),
            .len       (len[c]),
            .blk_ready (blk_ready[c]),
            .err       (err[c])
        );
    end

    assign cur_idx   = cur;
    assign cur_pend  = pend[cur_idx];
    assign cur_valid = fifo_rdata_valid[cur_idx];
    assign rd_fire   = (state == S_READ) && (cnt != '0) && !fifo_empty[cur_idx];
    assign word_ok   = cur_valid && (outstanding != '0);
    assign last_ret  = cur_valid && (outstanding == LEN_W'(1));

    always_comb begin
        fifo_read_req          = '0;
        fifo_read_req[cur_idx] = rd_fire;
    end

    // Zero-length blocks are retired straight from WAIT; real blocks retire on their last return.
    always_comb begin
        clr = '0;
        if (state == S_WAIT && cur_pend && len[cur_idx] == '0)
            clr[cur_idx] = 1'b1;
        if (state == S_DRAIN && last_ret)
            clr[cur_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT;
            cur         <= CH_Y;
            cnt         <= '0;
            outstanding <= '0;
        end else begin
            if (word_ok)
                outstanding <= outstanding - LEN_W'(1);
            case (state)
                S_WAIT: begin
                    if (cur_pend) begin
                        if (len[cur_idx] != '0) begin
                            cnt         <= len[cur_idx];
                            outstanding <= len[cur_idx];
                            state       <= S_READ;
                        end else begin
                            cur <= next_chan(cur);
                        end
                    end
                end
                S_READ: begin
                    if (rd_fire) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_ret) begin
                        cur   <= next_chan(cur);
                        state <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_chan  <= 2'd0;
            out_last  <= 1'b0;
            mcu_done  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            out_valid <= word_ok;
            out_data  <= word_ok ? fifo_rdata[cur_idx] : 32'd0;
            out_chan  <= word_ok ? cur_idx : 2'd0;
            out_last  <= last_ret;
            mcu_done  <= last_ret && (cur == CH_CR);
            proto_err <= proto_err | (|err);
        end
    end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// tb/tb_fifo_read_scheduler.sv - scoreboard bench for fifo_read_scheduler with behavioural FIFOs
module tb_fifo_read_scheduler;

    localparam int LEN_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [2:0]            blk_done;
    logic [2:0][LEN_W-1:0] blk_words;
    logic [2:0]            blk_ready;
    logic [2:0]            fifo_empty;
    logic [2:0]            fifo_rdata_valid;
    logic [2:0][31:0]      fifo_rdata;
    logic [2:0]            fifo_read_req;
    logic [31:0]           out_data;
    logic                  out_valid;
    logic [1:0]            out_chan;
    logic                  out_last;
    logic                  mcu_done;
    logic                  proto_err;

    always #5 clk = ~clk;

    fifo_read_scheduler #(.LEN_W(LEN_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .blk_done         (blk_done),
        .blk_words        (blk_words),
        .blk_ready        (blk_ready),
        .fifo_empty       (fifo_empty),
        .fifo_rdata_valid (fifo_rdata_valid),
        .fifo_rdata       (fifo_rdata),
        .fifo_read_req    (fifo_read_req),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_chan         (out_chan),
        .out_last         (out_last),
        .mcu_done         (mcu_done),
        .proto_err        (proto_err)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  ch;
        logic        last;
        logic        mcu;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    int          rr    = 0;
    logic [31:0] fq   [3][$];
    logic [31:0] wq   [3][$];
    int          blkq [3][$];
    exp_t        exp_q[$];
    logic [31:0] tmpq [$];
    logic [31:0] w16  [16];
    logic [2:0]  rd_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check read requests, score the output register, then model the FIFO read port.
    task automatic cycle();
        exp_t e;
        #2;
        rd_s = fifo_read_req;
        check("read_while_empty", 64'(rd_s & fifo_empty), 64'd0);
        check("read_not_onehot", 64'($onehot0(rd_s)), 64'd1);
        @(posedge clk);
        #1;
        if (out_valid) begin
            n_out++;
            check("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_word", 64'({out_data, out_chan, out_last, mcu_done}), 64'(e));
            end
        end else begin
            check("idle_flags", 64'({out_last, mcu_done}), 64'd0);
        end
        for (int c = 0; c < 3; c++) begin
            fifo_rdata_valid[c] = 1'b0;
            if (rst) begin
                fq[c].delete();
            end else if (rd_s[c] && fq[c].size() != 0) begin
                fifo_rdata[c]       = fq[c].pop_front();
                fifo_rdata_valid[c] = 1'b1;
            end
            fifo_empty[c] = (fq[c].size() == 0);
        end
    endtask

    task automatic model_word(input int c, input logic [31:0] d);
        wq[c].push_back(d);
    endtask

    task automatic fifo_push(input int c, input logic [31:0] d);
        fq[c].push_back(d);
        fifo_empty[c] = 1'b0;
    endtask

    task automatic write_word(input int c, input logic [31:0] d);
        model_word(c, d);
        fifo_push(c, d);
    endtask

    // Whole blocks are granted strictly round-robin from Y; a missing block stalls everything behind it.
    task automatic emit();
        int   n;
        exp_t e;
        while (blkq[rr].size() != 0) begin
            n = blkq[rr].pop_front();
            for (int i = 0; i < n; i++) begin
                e.d    = wq[rr].pop_front();
                e.ch   = 2'(rr);
                e.last = (i == n - 1);
                e.mcu  = (i == n - 1) && (rr == 2);
                exp_q.push_back(e);
            end
            rr = (rr + 1) % 3;
        end
    endtask

    task automatic signal(input int c, input int words);
        blk_done[c]  = 1'b1;
        blk_words[c] = LEN_W'(words);
        blkq[c].push_back(words > 16 ? 16 : words);
        emit();
        cycle();
        blk_done[c]  = 1'b0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        rr = 0;
        for (int c = 0; c < 3; c++) begin
            wq[c].delete();
            blkq[c].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_outputs"}, 64'({out_data, out_valid, out_chan, out_last, mcu_done,
                                      proto_err, fifo_read_req}), 64'd0);
        check({tag, "_blk_ready"}, 64'(blk_ready), 64'd7);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            cycle();
            guard++;
        end
        repeat (4) cycle();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int g;
        int c;
        int len;
        int eff;
        int p;
        int off;
        logic [31:0] d;

        rst              = 1'b1;
        blk_done         = '0;
        blk_words        = '0;
        fifo_empty       = 3'b111;
        fifo_rdata_valid = '0;
        fifo_rdata       = '0;
        repeat (2) cycle();
        rst = 1'b0;
        check_reset_vals("reset");

        // Full MCU Y4/Cb2/Cr3 with the first-read latency pinned down.
        base = n_out;
        for (int i = 0; i < 4; i++) write_word(0, 32'hA0 + 32'(i));
        for (int i = 0; i < 2; i++) write_word(1, $urandom());
        for (int i = 0; i < 3; i++) write_word(2, $urandom());
        signal(0, 4);
        cycle();
        check("no_req_first_cycle", 64'(rd_s), 64'd0);
        cycle();
        check("first_req_t_plus_2", 64'(rd_s), 64'd1);
        signal(1, 2);
        signal(2, 3);
        drain("mcu_drain");
        check("mcu_word_count", 64'(n_out - base), 64'd9);
        check("mcu_no_proto_err", 64'(proto_err), 64'd0);

        // Cr and Cb announced first: nothing may be read until Y arrives.
        do_reset();
        for (int i = 0; i < 3; i++) write_word(2, $urandom());
        signal(2, 3);
        for (int i = 0; i < 2; i++) write_word(1, $urandom());
        signal(1, 2);
        repeat (6) begin
            cycle();
            check("no_read_before_y", 64'(rd_s), 64'd0);
        end
        for (int i = 0; i < 2; i++) write_word(0, $urandom());
        signal(0, 2);
        drain("out_of_order_drain");

        // 16-word Y block announced with an oversize count, FIFO trickle-fed every 3 cycles.
        do_reset();
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            w16[i] = $urandom();
            model_word(0, w16[i]);
        end
        fifo_push(0, w16[0]);
        signal(0, 20);
        for (int i = 1; i < 16; i++) begin
            repeat (3) cycle();
            fifo_push(0, w16[i]);
        end
        drain("trickle_drain");
        check("trickle_count", 64'(n_out - base), 64'd16);

        // Zero-length Y block is skipped, single-word Cb follows.
        do_reset();
        base = n_out;
        signal(0, 0);
        write_word(1, $urandom());
        signal(1, 1);
        drain("zero_len_drain");
        check("zero_len_count", 64'(n_out - base), 64'd1);

        // Duplicate Y blk_done while the first is pending.
        do_reset();
        base = n_out;
        for (int i = 0; i < 3; i++) write_word(0, $urandom());
        signal(0, 3);
        check("blk_ready_while_pend", 64'(blk_ready[0]), 64'd0);
        blk_done[0]  = 1'b1;
        blk_words[0] = LEN_W'(7);
        cycle();
        blk_done[0]  = 1'b0;
        check("proto_err_set", 64'(proto_err), 64'd1);
        drain("dup_drain");
        check("dup_count", 64'(n_out - base), 64'd3);
        check("proto_err_sticky", 64'(proto_err), 64'd1);

        // Reset lands after 2 of 5 words; a fresh block then runs cleanly.
        do_reset();
        check_reset_vals("clear_err");
        base = n_out;
        for (int i = 0; i < 5; i++) write_word(0, $urandom());
        signal(0, 5);
        g = 0;
        while (n_out - base < 2 && g < 50) begin
            cycle();
            g++;
        end
        check("midblock_two_words", 64'(n_out - base), 64'd2);
        do_reset();
        check_reset_vals("midblock_reset");
        base = n_out;
        for (int i = 0; i < 3; i++) write_word(0, $urandom());
        signal(0, 3);
        drain("after_reset_drain");
        check("after_reset_count", 64'(n_out - base), 64'd3);

        // Random MCUs: random lengths (some oversize), partial pre-fill, random gaps and order.
        do_reset();
        for (int m = 0; m < 6; m++) begin
            off = $urandom_range(0, 2);
            for (int k = 0; k < 3; k++) begin
                c = (k + off) % 3;
                g = 0;
                while (!blk_ready[c] && g < 300) begin
                    cycle();
                    g++;
                end
                check("rand_ready_wait", 64'(blk_ready[c]), 64'd1);
                len = $urandom_range(0, 20);
                eff = (len > 16) ? 16 : len;
                p   = $urandom_range(0, eff);
                tmpq.delete();
                for (int i = 0; i < eff; i++) begin
                    d = $urandom();
                    model_word(c, d);
                    if (i < p) fifo_push(c, d);
                    else       tmpq.push_back(d);
                end
                signal(c, len);
                while (tmpq.size() != 0) begin
                    repeat ($urandom_range(0, 2)) cycle();
                    fifo_push(c, tmpq.pop_front());
                end
                repeat ($urandom_range(0, 3)) cycle();
            end
        end
        drain("rand_drain");
        check("rand_no_proto_err", 64'(proto_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
